// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// inst_fetch_queue : circular instruction queue between fetch and decode.
// Revision: 1.0
// ============================================================================
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          In_Valid,
  input  logic [31:0]   In_Inst,
  input  logic [31:0]   In_PC4,
  output logic          In_Ready,
  input  logic          Flush,
  output logic          Out_Valid,
  output logic [31:0]   Out_Inst,
  output logic [31:0]   Out_PC4,
  input  logic          Out_Ready,
  output logic [CW-1:0] Count,
  output logic          Drop
);

  localparam int            AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] c_ONE  = AW'(1);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_q, drop_d;
  logic          w_push, w_pop;

  // Ready is decoded from the registered count only, so a pop in the same
  // cycle can never free a slot for a push while full.
  assign In_Ready  = (count_q < c_FULL);
  assign Out_Valid = (count_q != '0);
  assign Out_Inst  = Out_Valid ? mem_q[head_q][31:0]  : 32'h0000_0000;
  assign Out_PC4   = Out_Valid ? mem_q[head_q][63:32] : 32'h0000_0000;
  assign Count     = count_q;
  assign Drop      = drop_q;

  always_comb begin
    w_push  = In_Valid & In_Ready & ~Flush & ~Reset;
    w_pop   = Out_Valid & Out_Ready & ~Flush & ~Reset;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = In_Valid & ~In_Ready & ~Flush;
    if (w_push) tail_d = tail_q + c_ONE;
    if (w_pop)  head_d = head_q + c_ONE;
    if (w_push && !w_pop)      count_d = count_q + CW'(1);
    else if (w_pop && !w_push) count_d = count_q - CW'(1);
    if (Flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is never cleared; only pointers and count define validity.
  always_ff @(posedge Clock) begin
    if (w_push) mem_q[tail_q] <= {In_PC4, In_Inst};
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// Testbench for inst_fetch_queue: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          Clock = 1'b0;
  logic          Reset, In_Valid, Flush, Out_Ready;
  logic [31:0]   In_Inst, In_PC4;
  logic          In_Ready, Out_Valid, Drop;
  logic [31:0]   Out_Inst, Out_PC4;
  logic [CW-1:0] Count;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  inst_fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .In_Valid (In_Valid),
    .In_Inst  (In_Inst),
    .In_PC4   (In_PC4),
    .In_Ready (In_Ready),
    .Flush    (Flush),
    .Out_Valid(Out_Valid),
    .Out_Inst (Out_Inst),
    .Out_PC4  (Out_PC4),
    .Out_Ready(Out_Ready),
    .Count    (Count),
    .Drop     (Drop)
  );

  typedef struct {
    logic        rst, fl, iv;
    logic [31:0] inst, pc4;
    logic        ordy;
    int          cnt;
    logic        ov;
    logic [31:0] oinst, opc4;
    logic        ird, drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic [31:0] inst,
                              logic [31:0] pc4, logic ordy, int cnt, logic ov,
                              logic [31:0] oinst, logic [31:0] opc4,
                              logic ird, logic drop);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.inst = inst; v.pc4 = pc4;
    v.ordy = ordy; v.cnt = cnt; v.ov = ov; v.oinst = oinst; v.opc4 = opc4;
    v.ird = ird; v.drop = drop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] inst, input logic [31:0] pc4, input logic ordy);
    Reset = rst; Flush = fl; In_Valid = iv; In_Inst = inst; In_PC4 = pc4; Out_Ready = ordy;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input int cnt, input logic ov,
                         input logic [31:0] oinst, input logic [31:0] opc4,
                         input logic ird, input logic drop);
    chk({tag, ".count"},    32'(Count),     32'(cnt));
    chk({tag, ".out_valid"}, 32'(Out_Valid), 32'(ov));
    chk({tag, ".out_inst"},  Out_Inst,       oinst);
    chk({tag, ".out_pc4"},   Out_PC4,        opc4);
    chk({tag, ".in_ready"},  32'(In_Ready),  32'(ird));
    chk({tag, ".drop"},      32'(Drop),      32'(drop));
  endtask

  localparam logic [31:0] A = 32'h2008_0005, B = 32'h2009_0006, C = 32'h200a_0007;
  localparam logic [31:0] D = 32'h200b_0008, E = 32'hdead_beef, F = 32'h0109_5020;
  localparam logic [31:0] G = 32'h1111_1111, H = 32'h2222_2222, I = 32'h3333_3333;
  localparam logic [31:0] J = 32'h4444_4444, K = 32'h5555_5555, L = 32'h6666_6666;

  logic [63:0] mq[$];
  logic        r, f, iv, ordy, rdy, exp_drop;
  logic [31:0] ri, rp;
  logic [63:0] hd;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // rst fl iv inst pc4 ordy | cnt ov oinst opc4 ird drop
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,       0, 0, 0, 0,     1, 0));
    vecs.push_back(mk(0, 0, 1, A, 32'h04, 0,  1, 1, A, 32'h04, 1, 0));
    vecs.push_back(mk(0, 0, 1, B, 32'h08, 0,  2, 1, A, 32'h04, 1, 0));
    vecs.push_back(mk(0, 0, 1, C, 32'h0c, 0,  3, 1, A, 32'h04, 1, 0));
    vecs.push_back(mk(0, 0, 1, D, 32'h10, 0,  4, 1, A, 32'h04, 0, 0));
    vecs.push_back(mk(0, 0, 1, E, 32'h14, 0,  4, 1, A, 32'h04, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,       4, 1, A, 32'h04, 0, 0));
    vecs.push_back(mk(0, 0, 1, F, 32'h18, 1,  3, 1, B, 32'h08, 1, 1));
    vecs.push_back(mk(0, 0, 1, F, 32'h18, 0,  4, 1, B, 32'h08, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,       3, 1, C, 32'h0c, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,       2, 1, D, 32'h10, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,       1, 1, F, 32'h18, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,       0, 0, 0, 0,      1, 0));
    vecs.push_back(mk(0, 0, 1, G, 32'h1c, 0,  1, 1, G, 32'h1c, 1, 0));
    vecs.push_back(mk(0, 0, 1, H, 32'h20, 0,  2, 1, G, 32'h1c, 1, 0));
    vecs.push_back(mk(0, 1, 1, I, 32'h24, 1,  0, 0, 0, 0,      1, 0));
    vecs.push_back(mk(0, 0, 1, J, 32'h28, 0,  1, 1, J, 32'h28, 1, 0));
    vecs.push_back(mk(0, 0, 1, K, 32'h2c, 0,  2, 1, J, 32'h28, 1, 0));
    vecs.push_back(mk(0, 0, 1, L, 32'h30, 0,  3, 1, J, 32'h28, 1, 0));
    vecs.push_back(mk(1, 1, 1, A, 32'h34, 1,  0, 0, 0, 0,      1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].inst, vecs[i].pc4, vecs[i].ordy);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].oinst,
              vecs[i].opc4, vecs[i].ird, vecs[i].drop);
    end

    // Streaming push/pop across pointer wrap: count holds at 1.
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 32'hA000_0001, 32'd4, 0);
    tick();
    chk("stream.first_pc4", Out_PC4, 32'd4);
    chk("stream.first_cnt", 32'(Count), 32'd1);
    for (int k = 2; k <= 10; k++) begin
      drive(0, 0, 1, 32'hA000_0000 + 32'(k), 32'(4 * k), 1);
      tick();
      chk($sformatf("stream.pc4_%0d", k), Out_PC4, 32'(4 * k));
      chk($sformatf("stream.inst_%0d", k), Out_Inst, 32'hA000_0000 + 32'(k));
      chk($sformatf("stream.cnt_%0d", k), 32'(Count), 32'd1);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk_all("stream.drain", 0, 0, 0, 0, 1, 0);

    // Flush while full with an offered entry must not raise Drop.
    for (int k = 0; k < DEPTH; k++) begin
      drive(0, 0, 1, 32'hB000_0000 + 32'(k), 32'(k), 0);
      tick();
    end
    chk("fullflush.pre_ready", 32'(In_Ready), 32'd0);
    drive(0, 1, 1, 32'hBBBB_BBBB, 32'h99, 0);
    tick();
    chk_all("fullflush.post", 0, 0, 0, 0, 1, 0);

    // Randomized traffic against a list-based model.
    drive(1, 0, 0, 0, 0, 0);
    tick();
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      r    = ($urandom_range(0, 59) == 0);
      f    = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ri   = $urandom;
      rp   = $urandom;
      drive(r, f, iv, ri, rp, ordy);
      #1;
      chk("rnd.in_ready_comb", 32'(In_Ready), 32'(mq.size() < DEPTH));
      exp_drop = 1'b0;
      if (r || f) begin
        mq.delete();
      end else begin
        rdy      = (mq.size() < DEPTH);
        exp_drop = iv && !rdy;
        if (mq.size() > 0 && ordy) void'(mq.pop_front());
        if (iv && rdy) mq.push_back({rp, ri});
      end
      tick();
      hd = (mq.size() > 0) ? mq[0] : 64'h0;
      chk_all($sformatf("rnd%0d", c), mq.size(), mq.size() > 0, hd[31:0], hd[63:32],
              mq.size() < DEPTH, exp_drop);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The module SHALL expose these parameters, one per line:
- DEPTH, 4, number of entries; power of two, 2..16.
- CW, 3, width of Count; equals log2(DEPTH)+1.
REQ-002 The module SHALL expose these ports, one per line:
- Clock, input, 1, single rising-edge clock for all state.
- Reset, input, 1, synchronous, active-high reset.
- In_Valid, input, 1, fetch stage offers an entry this cycle.
- In_Inst, input, 32, fetched instruction word.
- In_PC4, input, 32, address of the fetched instruction plus 4.
- In_Ready, output, 1, queue accepts an entry this cycle.
- Flush, input, 1, redirect (taken branch, jump or jr); discard all entries.
- Out_Valid, output, 1, head entry is available to decode.
- Out_Inst, output, 32, head instruction word.
- Out_PC4, output, 32, head PC+4.
- Out_Ready, input, 1, decode consumes the head this cycle.
- Count, output, CW, number of occupied entries.
- Drop, output, 1, one-cycle pulse: In_Valid was high while In_Ready was low.
REQ-003 The design SHALL use one clock, Clock, and a synchronous, active-high reset, Reset.
REQ-004 All state SHALL update only on the rising edge of Clock.

Function
REQ-005 Storage SHALL be a circular buffer of DEPTH entries, each holding {In_PC4, In_Inst}, with a head pointer, a tail pointer and Count.
REQ-006 Push SHALL occur when In_Valid & In_Ready; the entry is written at tail and tail advances by 1 modulo DEPTH.
REQ-007 Pop SHALL occur when Out_Valid & Out_Ready; head advances by 1 modulo DEPTH.
REQ-008 In_Ready SHALL equal (Count < DEPTH), decoded from registered state only.
REQ-009 In_Ready SHALL have no combinational path from Out_Ready or Flush.
REQ-010 Out_Valid SHALL equal (Count != 0).
REQ-011 Out_Inst and Out_PC4 SHALL present the head entry combinationally from storage when Out_Valid=1.
REQ-012 Out_Inst and Out_PC4 SHALL be 32'h00000000 (NOP) when Out_Valid=0.
REQ-013 Latency SHALL be one cycle: an entry pushed at edge N is visible on Out_* after edge N.
REQ-014 There SHALL be no same-cycle bypass from In_* to Out_* when the queue is empty.
REQ-015 Simultaneous push and pop SHALL leave Count unchanged and advance both pointers; this is legal at any Count, including DEPTH-1.
REQ-016 When Count=DEPTH, push SHALL be blocked even if a pop occurs in the same cycle; full-queue throughput is one entry per cycle after the pop.
REQ-017 Push alone SHALL increment Count by 1; pop alone SHALL decrement it by 1; Count SHALL never exceed DEPTH or underflow below 0.
REQ-018 Flush SHALL override push and pop in the same cycle: at the edge, head=0, tail=0, Count=0, and any concurrent In_Valid entry is discarded.
REQ-019 Drop SHALL be registered, set for exactly one cycle after an edge where In_Valid=1 and In_Ready=0, and SHALL NOT assert for an entry discarded by Flush.
REQ-020 Storage contents SHALL be unchanged by pop and by Flush; only pointers and Count change.
REQ-021 Pointer wrap SHALL be seamless: after DEPTH pushes and DEPTH pops, entries SHALL emerge in exact push order.

Reset
REQ-022 While Reset=1 at an edge: head=0, tail=0, Count=0, Drop=0; therefore Out_Valid=0, Out_Inst=0, Out_PC4=0, In_Ready=1.
REQ-023 Reset SHALL dominate Flush, push and pop in the same cycle.
REQ-024 A Reset asserted mid-stream SHALL discard all entries; storage contents need not be cleared.

Verification
REQ-025 The bench SHALL cover these scenarios (DEPTH=4):
- Reset; push 0x20080005/PC4 0x4 with Out_Ready=0 -> after the edge Count=1, Out_Valid=1, Out_Inst=0x20080005, Out_PC4=0x4.
- Push 4 entries with Out_Ready=0, then In_Valid=1 for a 5th -> Count=4, In_Ready=0, Drop=1 for one cycle, and the 5th entry is never output.
- Full queue with In_Valid=1 and Out_Ready=1 for 1 cycle -> pop occurs, push blocked, Count=3; next cycle push accepted, Count=4.
- Count=2 with In_Valid=1, Out_Ready=1, Flush=1 -> Count=0, Out_Valid=0, Out_Inst=0, Drop=0; the next push appears as head.
- Continuous push/pop for 10 entries with PC4 = 4,8,...,40 -> outputs in order 4..40 across pointer wrap, Count steady at 1.
- Reset=1 with Flush=1 and Count=3 -> all reset values of REQ-022 hold after the edge.
